// File: rtl/prog_clock_divider.sv
// Programmable clock divider: registered clk_out with period N, high ceil(N/2), a tick on each rise,
// and divisor changes that take effect only at a period boundary. Optional macro CLKDIV_PERIOD_COUNT_EN adds period_count.
module prog_clock_divider #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 div_load,
    output logic                 div_ack,
    output logic                 clk_out,
    output logic                 tick
`ifdef CLKDIV_PERIOD_COUNT_EN
    ,
    output logic [15:0]          period_count
`endif
);

    localparam logic [DIV_WIDTH-1:0] ZERO      = DIV_WIDTH'(0);
    localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO       = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] DEFAULT_N = DIV_WIDTH'(DEFAULT_DIV);

    logic [DIV_WIDTH-1:0] div_active;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] pend_value;
    logic                 pend_valid;

    logic [DIV_WIDTH-1:0] last_cnt;
    logic [DIV_WIDTH-1:0] half_last;
    logic [DIV_WIDTH-1:0] load_value;
    logic                 wrap;

    logic [DIV_WIDTH-1:0] div_active_d;
    logic [DIV_WIDTH-1:0] cnt_d;
    logic [DIV_WIDTH-1:0] pend_value_d;
    logic                 pend_valid_d;
    logic                 clk_out_d;
    logic                 tick_d;
    logic                 div_ack_d;

    // half_last = ceil(N/2)-1, the count on which clk_out falls
    always_comb begin
        last_cnt   = div_active - ONE;
        half_last  = last_cnt >> 1;
        load_value = (div_value < TWO) ? TWO : div_value;
        wrap       = en && (cnt == last_cnt);
    end

    always_comb begin
        div_active_d = div_active;
        cnt_d        = cnt;
        pend_value_d = pend_value;
        pend_valid_d = pend_valid;
        clk_out_d    = clk_out;
        tick_d       = 1'b0;
        div_ack_d    = 1'b0;

        if (wrap) begin
            cnt_d     = ZERO;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
            if (pend_valid) begin
                div_active_d = pend_value;
                pend_valid_d = 1'b0;
                div_ack_d    = 1'b1;
            end
        end else if (en) begin
            cnt_d = cnt + ONE;
            if (cnt == half_last) begin
                clk_out_d = 1'b0;
            end
        end

        // A load on a wrap edge is captured after the swap, so it waits for the next wrap
        if (div_load) begin
            pend_value_d = load_value;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_active <= DEFAULT_N;
            cnt        <= DEFAULT_N - ONE;
            pend_value <= DEFAULT_N;
            pend_valid <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            div_ack    <= 1'b0;
        end else begin
            div_active <= div_active_d;
            cnt        <= cnt_d;
            pend_value <= pend_value_d;
            pend_valid <= pend_valid_d;
            clk_out    <= clk_out_d;
            tick       <= tick_d;
            div_ack    <= div_ack_d;
        end
    end

`ifdef CLKDIV_PERIOD_COUNT_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period_count <= 16'd0;
        end else if (tick_d) begin
            period_count <= period_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 16, giving the divisor and counter width in bits.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 2, giving the divisor active after reset (range 2..2^DIV_WIDTH-1).
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable; 0 freezes division.
REQ-006 The block SHALL have port div_value, input, DIV_WIDTH bits: requested divisor N.
REQ-007 The block SHALL have port div_load, input, 1 bit: a one-cycle strobe that requests div_value.
REQ-008 The block SHALL have port div_ack, output, 1 bit: a one-cycle pulse when the requested divisor takes effect.
REQ-009 The block SHALL have port clk_out, output, 1 bit: the registered divided clock.
REQ-010 The block SHALL have port tick, output, 1 bit: a one-clk_in-cycle pulse coincident with each rising edge of clk_out.

Function
REQ-011 The block SHALL hold an active divisor N, an internal counter cnt in 0..N-1, and a high length H = ceil(N/2).
REQ-012 On an edge with en=1 and cnt=N-1 (wrap), the block SHALL set cnt<=0, clk_out<=1 and tick<=1.
REQ-013 On an edge with en=1 and cnt=H-1 (N>=2), the block SHALL set clk_out<=0, and otherwise increment cnt.
REQ-014 Resulting waveform: period N clk_in cycles; high H, low N-H (even N 50%, odd N one extra high cycle).
REQ-015 The block SHALL drive tick to 0 on every edge that is not a wrap.
REQ-016 A requested divisor of 0 or 1 SHALL be clamped to 2 when captured.
REQ-017 On an edge with div_load=1, the block SHALL capture the (clamped) div_value into a pending register and set a pending flag.
REQ-018 div_load while a request is already pending SHALL overwrite the pending value; only one div_ack SHALL result.
REQ-019 The pending divisor SHALL become the active N on the first wrap strictly after its capture edge; div_ack=1 SHALL be asserted with that wrap's tick, and the pending flag SHALL be cleared.
REQ-020 If div_load coincides with a wrap edge, the current wrap SHALL use the old N, and the new N SHALL apply at the following wrap.
REQ-021 With en=0, cnt, clk_out and the active N SHALL hold, tick and div_ack SHALL be 0, and div_load SHALL still be captured.
REQ-022 Division SHALL resume from the held cnt when en returns to 1, with no glitch or shortened phase.
REQ-023 clk_out SHALL never change except on a clk_in rising edge, and no high or low phase SHALL be shorter than 1 clk_in cycle.

Reset
REQ-024 Asserting rst SHALL immediately force clk_out=0, tick=0, div_ack=0, pending cleared, N=DEFAULT_DIV and cnt=DEFAULT_DIV-1.
REQ-025 The first enabled edge after reset release SHALL be a wrap: clk_out rises and tick pulses.
REQ-026 A reset in mid-period or with a load pending SHALL discard the pending request, and no div_ack SHALL be issued for it.

Configuration
REQ-027 Macro CLKDIV_PERIOD_COUNT_EN, when defined, SHALL add output period_count (16 bits).
- Reset value: 0.
- Increments by 1 on every tick.
- Wraps from 0xFFFF to 0x0000.
REQ-028 Without CLKDIV_PERIOD_COUNT_EN, the period_count port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, en=1, DEFAULT_DIV=2 -> clk_out toggles every clk_in edge (high 1, low 1), and tick pulses every 2 cycles starting on the first edge.
REQ-030 Load div_value=5 mid-period with N=2 -> old period completes; at the next wrap div_ack=1 and tick=1; then clk_out is high 3 and low 2 cycles repeatedly.
REQ-031 Load div_value=6, then div_value=4 before the next wrap -> exactly one div_ack; N becomes 4 (high 2, low 2); 6 is never applied.
REQ-032 Load div_value=0 -> after ack, behaviour equals N=2; load div_value=1 -> same.
REQ-033 N=8; drop en for 5 cycles at cnt=2; raise en -> clk_out holds high during the freeze; the high phase totals 4 enabled cycles; the period resumes without glitch.
REQ-034 N=7; assert rst at cnt=4 with a load pending -> outputs are 0 immediately; no div_ack; after release N=DEFAULT_DIV and the first edge wraps; with CLKDIV_PERIOD_COUNT_EN, period_count=0 then increments by 1 on each tick.
